// File: rtl/necesidades_mascota.sv
// necesidades_mascota: virtual pet need tracker for N independent channels (food, medicine,
// sleep, play, ...). Each channel holds a saturating level that decays on a free-running tick
// and is refilled by a long button press. A mood FSM derived from all levels reports
// NORMAL/ALERTA/CRITICO/MUERTO.
//
// Ports:
//   clk_i               system clock
//   reset_i             asynchronous active-high reset
//   botones_i           raw async buttons, bit i = channel i
//   niveles_o           channel i level at [i*ANCHO_NIVEL +: ANCHO_NIVEL]
//   activo_o            channel i refill animation enable
//   alerta_o            channel i level <= UMBRAL
//   estado_o            0=NORMAL 1=ALERTA 2=CRITICO 3=MUERTO
//   tick_decaimiento_o  one-cycle pulse, coincident with each decay level update
module necesidades_mascota #(
  parameter int unsigned N_CANALES          = 2,
  parameter int unsigned ANCHO_NIVEL        = 3,
  parameter int unsigned CICLOS_PULSACION   = 250_000_000,
  parameter int unsigned CICLOS_DECAIMIENTO = 500_000_000,
  parameter int unsigned INCREMENTO         = 3,
  parameter int unsigned UMBRAL             = 2,
  parameter int unsigned DURACION_ACTIVO    = 50_000_000,
  parameter int unsigned TICKS_MUERTE       = 3
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [N_CANALES-1:0]             botones_i,
  output logic [N_CANALES*ANCHO_NIVEL-1:0] niveles_o,
  output logic [N_CANALES-1:0]             activo_o,
  output logic [N_CANALES-1:0]             alerta_o,
  output logic [1:0]                       estado_o,
  output logic                             tick_decaimiento_o
);

  localparam int unsigned AnchoPuls   = $clog2(CICLOS_PULSACION + 1);
  localparam int unsigned AnchoDec    = $clog2(CICLOS_DECAIMIENTO + 1);
  localparam int unsigned AnchoAct    = $clog2(DURACION_ACTIVO + 1);
  localparam int unsigned AnchoMuerte = $clog2(TICKS_MUERTE + 1);

  localparam logic [ANCHO_NIVEL-1:0] NivelMax   = {ANCHO_NIVEL{1'b1}};
  localparam logic [ANCHO_NIVEL:0]   NivelMaxEx = {1'b0, NivelMax};
  localparam logic [ANCHO_NIVEL:0]   IncEx      = (ANCHO_NIVEL + 1)'(INCREMENTO);
  localparam logic [ANCHO_NIVEL-1:0] UmbralN    = ANCHO_NIVEL'(UMBRAL);
  localparam logic [AnchoPuls-1:0]   PulsFin    = AnchoPuls'(CICLOS_PULSACION - 1);
  localparam logic [AnchoPuls-1:0]   PulsSat    = AnchoPuls'(CICLOS_PULSACION);
  localparam logic [AnchoDec-1:0]    DecFin     = AnchoDec'(CICLOS_DECAIMIENTO - 1);
  localparam logic [AnchoAct-1:0]    ActIni     = AnchoAct'(DURACION_ACTIVO);
  localparam logic [AnchoMuerte-1:0] MuerteUlt  = AnchoMuerte'(TICKS_MUERTE - 1);

  typedef enum logic [1:0] {
    StNormal  = 2'd0,
    StAlerta  = 2'd1,
    StCritico = 2'd2,
    StMuerto  = 2'd3
  } estado_e;

  estado_e                 estado_q, estado_d;
  logic [N_CANALES-1:0]    sync1_q, sync2_q;
  logic [AnchoPuls-1:0]    puls_q [N_CANALES];
  logic [AnchoPuls-1:0]    puls_d [N_CANALES];
  logic [ANCHO_NIVEL-1:0]  nivel_q [N_CANALES];
  logic [ANCHO_NIVEL-1:0]  nivel_d [N_CANALES];
  logic [AnchoAct-1:0]     act_q [N_CANALES];
  logic [AnchoAct-1:0]     act_d [N_CANALES];
  logic [N_CANALES-1:0]    alerta_q, alerta_d;
  logic [N_CANALES-1:0]    evento;
  logic [AnchoDec-1:0]     dec_q, dec_d;
  logic                    tick, tick_q;
  logic [AnchoMuerte-1:0]  muerte_q, muerte_d;
  logic                    muerto;
  logic                    algun_cero, alguna_alerta;
  logic [ANCHO_NIVEL:0]    suma [N_CANALES];

  assign muerto = (estado_q == StMuerto);

  // Decay timer: free-running, tick on the wrap cycle.
  assign tick  = (dec_q == DecFin);
  assign dec_d = tick ? '0 : dec_q + 1'b1;

  // Long-press detector: counter saturates one past the event point so a held button fires once.
  always_comb begin
    for (int unsigned i = 0; i < N_CANALES; i++) begin
      evento[i] = sync2_q[i] && (puls_q[i] == PulsFin);
      puls_d[i] = puls_q[i];
      if (!sync2_q[i]) begin
        puls_d[i] = '0;
      end else if (puls_q[i] != PulsSat) begin
        puls_d[i] = puls_q[i] + 1'b1;
      end
    end
  end

  // Level, animation and alert next state. A refill wins over a coincident decay tick.
  always_comb begin
    for (int unsigned i = 0; i < N_CANALES; i++) begin
      suma[i]    = {1'b0, nivel_q[i]} + IncEx;
      nivel_d[i] = nivel_q[i];
      act_d[i]   = act_q[i];
      if (muerto) begin
        act_d[i] = '0;
      end else begin
        if (evento[i]) begin
          nivel_d[i] = (suma[i] > NivelMaxEx) ? NivelMax : suma[i][ANCHO_NIVEL-1:0];
        end else if (tick && (nivel_q[i] != '0)) begin
          nivel_d[i] = nivel_q[i] - 1'b1;
        end
        if (evento[i]) begin
          act_d[i] = ActIni;
        end else if (act_q[i] != '0) begin
          act_d[i] = act_q[i] - 1'b1;
        end
      end
      alerta_d[i] = (nivel_d[i] <= UmbralN);
    end
  end

  always_comb begin
    algun_cero    = 1'b0;
    alguna_alerta = |alerta_q;
    for (int unsigned i = 0; i < N_CANALES; i++) begin
      if (nivel_q[i] == '0) algun_cero = 1'b1;
    end
  end

  // Mood FSM on registered levels; tick_q marks the cycle the decayed levels are visible.
  always_comb begin
    estado_d = estado_q;
    muerte_d = '0;
    case (estado_q)
      StNormal: begin
        if (algun_cero)         estado_d = StCritico;
        else if (alguna_alerta) estado_d = StAlerta;
      end
      StAlerta: begin
        if (algun_cero)          estado_d = StCritico;
        else if (!alguna_alerta) estado_d = StNormal;
      end
      StCritico: begin
        if (!algun_cero) begin
          estado_d = alguna_alerta ? StAlerta : StNormal;
        end else if (tick_q) begin
          if (muerte_q == MuerteUlt) begin
            estado_d = StMuerto;
          end else begin
            muerte_d = muerte_q + 1'b1;
          end
        end else begin
          muerte_d = muerte_q;
        end
      end
      StMuerto: estado_d = StMuerto;
      default:  estado_d = StNormal;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      alerta_q <= '0;
      dec_q    <= '0;
      tick_q   <= 1'b0;
      muerte_q <= '0;
      estado_q <= StNormal;
      for (int unsigned i = 0; i < N_CANALES; i++) begin
        puls_q[i]  <= '0;
        nivel_q[i] <= NivelMax;
        act_q[i]   <= '0;
      end
    end else begin
      sync1_q  <= botones_i;
      sync2_q  <= sync1_q;
      alerta_q <= alerta_d;
      dec_q    <= dec_d;
      tick_q   <= tick;
      muerte_q <= muerte_d;
      estado_q <= estado_d;
      for (int unsigned i = 0; i < N_CANALES; i++) begin
        puls_q[i]  <= puls_d[i];
        nivel_q[i] <= nivel_d[i];
        act_q[i]   <= act_d[i];
      end
    end
  end

  always_comb begin
    niveles_o = '0;
    activo_o  = '0;
    for (int unsigned i = 0; i < N_CANALES; i++) begin
      niveles_o[i*ANCHO_NIVEL +: ANCHO_NIVEL] = nivel_q[i];
      activo_o[i] = (act_q[i] != '0) && !muerto;
    end
  end

  assign alerta_o           = alerta_q;
  assign estado_o           = estado_q;
  assign tick_decaimiento_o = tick_q;

endmodule
